// File: rtl/control_unit_p.sv
// Instruction register plus fetch/decode/execute sequencer with an
// instruction-memory req/vld handshake, run/halt control, an illegal-opcode
// trap and an ALU-completion timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for run
// FETCH    | mem_req high, waiting for mem_vld to load the IR
// DECODE   | classify IR, pulse en_pc (or trap on illegal opcode)
// EXEC     | pulse en_group, clear the ALU wait counter
// WAIT_ALU | wait for alu_end, bounded by ALU_TMO cycles
// WB       | one-hot reg_en pulse for the destination register
// HALT     | halted high, waiting for run to resume fetching
// ERROR    | sticky fault, left only through reset
module control_unit_p #(
  parameter int INS_W   = 16,
  parameter int OP_W    = 4,
  parameter int RD_W    = 2,
  parameter int FUNC_W  = 4,
  parameter int ALU_TMO = 15,
  localparam int NREG   = 2 ** RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  input  logic              mem_vld,
  input  logic [INS_W-1:0]  mem_rdata,
  input  logic              alu_end,
  output logic              en_group,
  output logic              en_pc,
  output logic [1:0]        pc_ctrl,
  output logic [NREG-1:0]   reg_en,
  output logic              alu_in_sel,
  output logic [FUNC_W-1:0] alu_func,
  output logic [INS_W-1:0]  ir_out,
  output logic              halted,
  output logic [1:0]        fault
);

  localparam int CNT_W = $clog2(ALU_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_ALU, S_WB, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_LDI, K_JMP, K_JZ, K_HALT, K_ILL
  } kind_t;

  state_t            state, state_nx;
  kind_t             kind;
  logic [INS_W-1:0]  ir_nx;
  logic [1:0]        fault_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [OP_W-1:0]   op;
  logic [RD_W-1:0]   rd;
  logic              imm_bit;
  logic [FUNC_W-1:0] func_dec;
  logic              sel_dec;

  assign op      = ir_out[INS_W-1 -: OP_W];
  assign rd      = ir_out[INS_W-OP_W-1 -: RD_W];
  assign imm_bit = ir_out[INS_W-OP_W-RD_W-1];

  // Classify the held instruction; opcodes outside the known set trap.
  always_comb begin
    kind = K_ILL;
    if (op == OP_W'(0))       kind = K_NOP;
    else if (op <= OP_W'(9))  kind = K_ALU;
    else if (op == OP_W'(10)) kind = K_LDI;
    else if (op == OP_W'(11)) kind = K_JMP;
    else if (op == OP_W'(12)) kind = K_JZ;
    else if (op == OP_W'(15)) kind = K_HALT;
    func_dec = (kind == K_ALU) ? FUNC_W'(op) : '0;
    sel_dec  = (kind == K_ALU) ? imm_bit : (kind == K_LDI);
  end

  // Next-state and Moore outputs; outputs depend only on state and ir_out.
  always_comb begin
    state_nx   = state;
    ir_nx      = ir_out;
    fault_nx   = fault;
    cnt_nx     = cnt;
    mem_req    = 1'b0;
    en_pc      = 1'b0;
    en_group   = 1'b0;
    pc_ctrl    = 2'b00;
    reg_en     = '0;
    alu_in_sel = 1'b0;
    alu_func   = '0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nx = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_vld) begin
          ir_nx    = mem_rdata;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (kind == K_ILL) begin
          fault_nx = 2'b01;
          state_nx = S_ERROR;
        end else begin
          en_pc = 1'b1;
          case (kind)
            K_JMP:   pc_ctrl = 2'b10;
            K_JZ:    pc_ctrl = 2'b11;
            default: pc_ctrl = 2'b01;
          endcase
          case (kind)
            K_HALT:       state_nx = S_HALT;
            K_ALU, K_LDI: state_nx = S_EXEC;
            default:      state_nx = S_FETCH;
          endcase
        end
      end
      S_EXEC: begin
        en_group   = 1'b1;
        alu_func   = func_dec;
        alu_in_sel = sel_dec;
        cnt_nx     = '0;
        state_nx   = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        alu_func   = func_dec;
        alu_in_sel = sel_dec;
        // cnt counts completed wait cycles, so cnt == ALU_TMO-1 is the last one.
        if (alu_end) begin
          state_nx = S_WB;
        end else if (cnt == CNT_W'(ALU_TMO - 1)) begin
          fault_nx = 2'b10;
          state_nx = S_ERROR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WB: begin
        alu_func   = func_dec;
        alu_in_sel = sel_dec;
        reg_en     = NREG'(1) << rd;
        state_nx   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) state_nx = S_FETCH;
      end
      S_ERROR: begin
        state_nx = S_ERROR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, instruction register, sticky fault and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      ir_out <= '0;
      fault  <= 2'b00;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      ir_out <= ir_nx;
      fault  <= fault_nx;
      cnt    <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_control_unit_p.sv
module tb_control_unit_p;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        mem_req;
  logic        mem_vld = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        alu_end = 1'b0;
  logic        en_group, en_pc, alu_in_sel, halted;
  logic [1:0]  pc_ctrl, fault;
  logic [3:0]  reg_en, alu_func;
  logic [15:0] ir_out;

  control_unit_p dut (
    .clk(clk), .rst(rst), .run(run), .mem_req(mem_req), .mem_vld(mem_vld),
    .mem_rdata(mem_rdata), .alu_end(alu_end), .en_group(en_group), .en_pc(en_pc),
    .pc_ctrl(pc_ctrl), .reg_en(reg_en), .alu_in_sel(alu_in_sel), .alu_func(alu_func),
    .ir_out(ir_out), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // kind: 0 = en_pc, 1 = en_group, 2 = reg_en
  typedef struct { int kind; int val; } ev_t;
  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected strobe event whenever the DUT pulses one.
  always @(negedge clk) begin : mon
    int n;
    ev_t o, e;
    if (rst) begin
      n = int'(en_pc) + int'(en_group) + int'(reg_en != 4'd0);
      chk("one_strobe", int'(n <= 1), 1);
      if (!en_pc) chk("pc_ctrl_idle", int'(pc_ctrl), 0);
      if (n == 1) begin
        if (en_pc) begin
          o.kind = 0;
          o.val  = int'(pc_ctrl) * 32 + int'(alu_func) * 2 + int'(alu_in_sel);
        end else if (en_group) begin
          o.kind = 1;
          o.val  = int'(alu_func) * 2 + int'(alu_in_sel);
        end else begin
          o.kind = 2;
          o.val  = int'(reg_en) * 32 + int'(alu_func) * 2 + int'(alu_in_sel);
        end
        if (sb.size() == 0) begin
          chk("unexpected_strobe_kind", o.kind, -1);
        end else begin
          e = sb.pop_front();
          chk("strobe_kind", o.kind, e.kind);
          chk("strobe_val", o.val, e.val);
        end
      end
    end
  end

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Asynchronous reset pulse between clock edges; leftover = expected strobes never seen.
  task automatic do_reset(input int leftover);
    @(negedge clk);
    #2;
    rst = 1'b0; run = 1'b0; mem_vld = 1'b0; alu_end = 1'b0;
    #1;
    chk("rst_ir", int'(ir_out), 0);
    chk("rst_ctl", int'({mem_req, en_pc, en_group, pc_ctrl, reg_en, alu_in_sel,
                         alu_func, halted, fault}), 0);
    chk("sb_left", sb.size(), leftover);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_req", int'(mem_req), 0);
    run = 1'b1;
  endtask

  // Issue one instruction. alu_d: >0 alu_end on that WAIT cycle, 0 timeout, <0 reset mid-wait.
  task automatic issue(input logic [15:0] ins, input int vdly, input int alu_d);
    int op, rd, func, sel, pcc;
    bit ok;
    op   = int'(ins[15:12]);
    rd   = int'(ins[11:10]);
    func = (op >= 1 && op <= 9) ? op : 0;
    sel  = (op >= 1 && op <= 9) ? int'(ins[9]) : (op == 10 ? 1 : 0);
    pcc  = (op == 11) ? 2 : (op == 12) ? 3 : 1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = mem_req;
    end
    chk("req_seen", int'(ok), 1);
    if (!ok) return;
    repeat (vdly) @(negedge clk);
    if (op == 15) run = 1'b0;
    mem_vld = 1'b1;
    mem_rdata = ins;
    if (op != 13 && op != 14) push(0, pcc * 32);
    if (op >= 1 && op <= 10) begin
      push(1, func * 2 + sel);
      if (alu_d > 0) push(2, (1 << rd) * 32 + func * 2 + sel);
      else if (alu_d < 0) push(2, 0);
    end
    @(negedge clk);
    mem_vld = 1'b0;
    mem_rdata = 16'($urandom);
    chk("ir_load", int'(ir_out), int'(ins));
    chk("req_drop", int'(mem_req), 0);
    if (op == 13 || op == 14) begin
      @(negedge clk);
      chk("fault_ill", int'(fault), 1);
      repeat (3) @(negedge clk);
      chk("err_no_req", int'(mem_req), 0);
      chk("err_fault_held", int'(fault), 1);
      do_reset(0);
    end else if (op == 15) begin
      @(negedge clk);
      chk("halted", int'(halted), 1);
      chk("halt_no_req", int'(mem_req), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("halt_hold", int'(halted), 1);
      run = 1'b1;
      @(negedge clk);
      chk("resume_halted", int'(halted), 0);
      chk("resume_req", int'(mem_req), 1);
    end else if (op == 0 || op >= 11) begin
      @(negedge clk);
      chk("req_again", int'(mem_req), 1);
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 6 && !ok; i++) begin
        @(negedge clk);
        ok = en_group;
      end
      chk("grp_seen", int'(ok), 1);
      if (!ok) return;
      mem_vld = 1'b1;
      mem_rdata = ~ins;
      if (alu_d > 0) begin
        repeat (alu_d) @(negedge clk);
        alu_end = 1'b1;
        @(negedge clk);
        alu_end = 1'b0;
        mem_vld = 1'b0;
        chk("ir_stable", int'(ir_out), int'(ins));
        chk("wb_fault", int'(fault), 0);
        @(negedge clk);
        chk("req_after_wb", int'(mem_req), 1);
      end else if (alu_d == 0) begin
        repeat (15) @(negedge clk);
        chk("tmo_early", int'(fault), 0);
        @(negedge clk);
        mem_vld = 1'b0;
        chk("tmo_fault", int'(fault), 2);
        chk("tmo_no_req", int'(mem_req), 0);
        do_reset(0);
      end else begin
        repeat (-alu_d) @(negedge clk);
        mem_vld = 1'b0;
        do_reset(1);
      end
    end
  endtask

  initial begin
    #1;
    chk("init_ir", int'(ir_out), 0);
    chk("init_ctl", int'({mem_req, en_pc, en_group, pc_ctrl, reg_en, alu_in_sel,
                          alu_func, halted, fault}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_wait_run", int'(mem_req), 0);
    run = 1'b1;
    issue(16'h1A05, 2, 3);
    issue(16'hB000, 1, 0);
    issue(16'hC000, 0, 0);
    issue(16'hD000, 0, 0);
    issue(16'h2400, 0, 0);
    issue(16'h2400, 1, 15);
    issue(16'hA100, 0, 1);
    issue(16'hF000, 0, 0);
    issue(16'h3C80, 1, -4);
    for (int n = 0; n < 50; n++) begin
      logic [15:0] ins;
      int r, d;
      ins = 16'($urandom);
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 0 : (r == 1) ? 15 : int'($urandom_range(1, 14));
      issue(ins, int'($urandom_range(0, 3)), d);
    end
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
